// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: a main entry feeding decode plus an optional skid entry,
// with valid/ready handshakes on both sides and a synchronous flush.
module if_id_stage #(
    parameter int unsigned     IR_W   = 32,
    parameter int unsigned     PC_W   = 32,
    parameter logic [IR_W-1:0] NOP_IR = {IR_W{1'b0}},
    parameter bit              SKID   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            IF_valid,
    output logic            IF_ready,
    input  logic [IR_W-1:0] IF_ir,
    input  logic [PC_W-1:0] IF_npc,
    output logic            ID_valid,
    input  logic            ID_ready,
    output logic [IR_W-1:0] ID_ir,
    output logic [PC_W-1:0] ID_npc,
    output logic [1:0]      occ
);

    logic            main_full_q, main_full_d;
    logic [IR_W-1:0] main_ir_q,   main_ir_d;
    logic [PC_W-1:0] main_npc_q,  main_npc_d;
    logic            skid_full_q, skid_full_d;
    logic [IR_W-1:0] skid_ir_q,   skid_ir_d;
    logic [PC_W-1:0] skid_npc_q,  skid_npc_d;

    logic accept;
    logic consume;

    // With a skid entry the upstream ready comes straight from a flop, so
    // ID_ready never reaches IF_ready combinationally.
    always_comb begin
        if (SKID) begin
            IF_ready = !skid_full_q;
        end else begin
            IF_ready = !main_full_q || ID_ready;
        end
    end

    assign accept  = IF_valid && IF_ready;
    assign consume = main_full_q && ID_ready;

    always_comb begin
        main_full_d = main_full_q;
        main_ir_d   = main_ir_q;
        main_npc_d  = main_npc_q;
        skid_full_d = skid_full_q;
        skid_ir_d   = skid_ir_q;
        skid_npc_d  = skid_npc_q;

        if (flush) begin
            main_full_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (SKID) begin
            // Main is always the older beat; the skid entry only refills main.
            if (skid_full_q) begin
                if (consume) begin
                    main_ir_d   = skid_ir_q;
                    main_npc_d  = skid_npc_q;
                    skid_full_d = 1'b0;
                end
            end else if (!main_full_q) begin
                if (accept) begin
                    main_full_d = 1'b1;
                    main_ir_d   = IF_ir;
                    main_npc_d  = IF_npc;
                end
            end else if (consume) begin
                if (accept) begin
                    main_ir_d  = IF_ir;
                    main_npc_d = IF_npc;
                end else begin
                    main_full_d = 1'b0;
                end
            end else if (accept) begin
                skid_full_d = 1'b1;
                skid_ir_d   = IF_ir;
                skid_npc_d  = IF_npc;
            end
        end else begin
            if (accept) begin
                main_full_d = 1'b1;
                main_ir_d   = IF_ir;
                main_npc_d  = IF_npc;
            end else if (consume) begin
                main_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_full_q <= 1'b0;
            main_ir_q   <= '0;
            main_npc_q  <= '0;
            skid_full_q <= 1'b0;
            skid_ir_q   <= '0;
            skid_npc_q  <= '0;
        end else begin
            main_full_q <= main_full_d;
            main_ir_q   <= main_ir_d;
            main_npc_q  <= main_npc_d;
            skid_full_q <= skid_full_d;
            skid_ir_q   <= skid_ir_d;
            skid_npc_q  <= skid_npc_d;
        end
    end

    assign ID_valid = main_full_q;
    assign ID_ir    = main_full_q ? main_ir_q : NOP_IR;
    assign ID_npc   = main_npc_q;
    assign occ      = {1'b0, main_full_q} + {1'b0, skid_full_q};

endmodule
